deco: RTL and testbench
=======================

# deco

Instruction-decode stage of the 32-bit pipelined processor. It holds the 16×32 general-purpose register file and reads two source operands (Ra, Rb). It sign-extends the 19-bit immediate and forwards the destination register index. It also produces the branch-select and branch-target signals consumed by the fetch stage. Register writes come back from write-back through DataInput under RWrite control.

## Interface
- Clock `clk`; reset `rst`. Reset is synchronous and active-high.
- No parameters. Widths are fixed: 16 registers, 32-bit data, 19-bit immediate.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `Ra` in 4: source register A index.
- `Rb` in 4: source register B index.
- `Rd` in 4: destination/write register index.
- `Branch` in 1: current instruction is a branch.
- `DataInputON` in 1: write-data select. 1 selects DataInput; 0 selects ImmExtend.
- `RWrite` in 1: register-file write enable.
- `Imm` in 19: raw immediate field.
- `DataInput` in 32: write-back data.
- `PCSelect` out 1: selects the branch target at fetch.
- `BranchDir` out 32: branch target address.
- `ImmExtend` out 32: sign-extended immediate.
- `Data1` out 32: value of register Ra.
- `Data2` out 32: value of register Rb.
- `RD` out 4: destination index forwarded to later stages.

## Operation
- Register file: 16 entries × 32 bits. All 16 entries, including R0, are ordinary writable registers.
- Reads:
  - Combinational, asynchronous.
  - Data1 = reg[Ra]; Data2 = reg[Rb].
- Write:
  - Occurs on the rising clk edge when RWrite=1 and rst=0.
  - reg[Rd] ← (DataInputON ? DataInput : ImmExtend).
  - RWrite=0 leaves the register file unchanged.
- Read-during-write: a read of the register being written returns the old value until the edge. There is no internal bypass.
- ImmExtend = {{13{Imm[18]}}, Imm}: two's-complement sign extension.
- BranchDir = ImmExtend. The value is the absolute target and no shift is applied.
- PCSelect = Branch, combinational.
- RD = Rd, combinational passthrough.
- X/undefined inputs before the first stimulus need no defined handling. Outputs follow inputs once the inputs are driven.

## Timing
- Reset:
  - On a rising edge with rst=1, all 16 registers clear to 0.
  - A write requested in the same cycle is ignored; reset wins.
  - After reset, Data1 = Data2 = 0 for any Ra/Rb.
  - PCSelect, BranchDir, ImmExtend and RD stay combinational in their inputs and are not affected by reset.
- Write latency: 1 edge. A value written at edge N is visible on Data1/Data2 in the cycle after edge N.
- Read latency: 0 cycles (combinational from Ra/Rb).
- Simultaneous events:
  - Ra = Rb = Rd with RWrite=1: both Data1 and Data2 show the old value before the edge and the new value after it.
  - rst=1 together with RWrite=1: the register is cleared, not written.
- No handshake and no stall. One operation per cycle.

## Structure
- Shared package (`proc_pkg`) holds:
  - `DATA_W`=32, `REG_IDX_W`=4, `NUM_REGS`=16, `IMM_W`=19.
  - The typedefs `word_t` (logic [31:0]) and `reg_idx_t` (logic [3:0]).
- Sub-module `reg_file`:
  - 2 asynchronous read ports and 1 synchronous write port, with synchronous reset.
  - `deco` instantiates it and contains the write-data mux, the sign extender and the branch/RD passthrough logic.

## Test plan
- Reset then read:
  - Stimulus: rst=1 for one edge, then Ra=5, Rb=3.
  - Required: Data1=0, Data2=0.
- Write from DataInput:
  - Stimulus: Rd=2, RWrite=1, DataInputON=1, DataInput=10, Imm=8, one edge; then RWrite=0, Ra=2.
  - Required: Data1=10 and ImmExtend=8.
- Write suppressed:
  - Stimulus: Rd=4, RWrite=0, DataInput=11, one edge; then Ra=4.
  - Required: Data1=0, and R2 still reads 10.
- Immediate write and sign extension:
  - Stimulus: Imm=19'h40000, DataInputON=0, RWrite=1, Rd=7, one edge; then Rb=7.
  - Required: ImmExtend=32'hFFFC0000 and Data2=32'hFFFC0000.
- Branch:
  - Stimulus: Branch=1, Imm=19'd100.
  - Required: PCSelect=1, BranchDir=100.
  - Stimulus: then Branch=0.
  - Required: PCSelect=0.
- Read-during-write and reset priority:
  - Stimulus: Ra=Rb=Rd=9, RWrite=1, DataInputON=1, DataInput=32'hDEADBEEF.
  - Required: Data1=Data2=0 before the edge and 32'hDEADBEEF after it.
  - Stimulus: next cycle rst=1 and RWrite=1 with DataInput=5.
  - Required: R9 reads 0; RD tracks Rd throughout.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared widths, types and small helpers for the processor pipeline stages.
package proc_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 4;
   localparam int NUM_REGS  = 16;
   localparam int IMM_W     = 19;

   typedef logic [DATA_W-1:0]    word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [IMM_W-1:0]     imm_t;

   // Two's-complement sign extension of the raw immediate field to a full word.
   function automatic word_t sign_ext(input imm_t imm);
      return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage : proc_pkg

// File: rtl/reg_file.sv
// 16 x 32 general-purpose register file: two asynchronous read ports,
// one synchronous write port, synchronous active-high clear of every entry.
// There is no write-to-read bypass: a read of the entry being written
// returns the old contents until the clock edge commits the write.
module reg_file
   import proc_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  reg_idx_t raddr_a,
   input  reg_idx_t raddr_b,
   input  reg_idx_t waddr,
   input  logic     wen,
   input  word_t    wdata,
   output word_t    rdata_a,
   output word_t    rdata_b
);

   word_t regs_r [NUM_REGS];

   // Storage update: reset clears all entries and overrides any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wen) begin
         regs_r[waddr] <= wdata;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      rdata_a = regs_r[raddr_a];
      rdata_b = regs_r[raddr_b];
   end

endmodule : reg_file

// File: rtl/deco.sv
// Instruction-decode stage: register file access, immediate sign extension,
// write-back data selection and the branch/destination passthroughs that
// feed fetch and the later pipeline stages.
module deco
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Ra,
   input  logic [3:0]  Rb,
   input  logic [3:0]  Rd,
   input  logic        Branch,
   input  logic        DataInputON,
   input  logic        RWrite,
   input  logic [18:0] Imm,
   input  logic [31:0] DataInput,
   output logic        PCSelect,
   output logic [31:0] BranchDir,
   output logic [31:0] ImmExtend,
   output logic [31:0] Data1,
   output logic [31:0] Data2,
   output logic [3:0]  RD
);

   word_t imm_ext_s;
   word_t wr_data_s;

   // Sign extension, branch target and passthroughs are purely combinational.
   always_comb begin
      imm_ext_s = sign_ext(Imm);
      ImmExtend = imm_ext_s;
      BranchDir = imm_ext_s;
      PCSelect  = Branch;
      RD        = Rd;
   end

   // Write-back data select: external write-back data or the extended immediate.
   always_comb begin
      if (DataInputON) begin
         wr_data_s = DataInput;
      end else begin
         wr_data_s = imm_ext_s;
      end
   end

   reg_file u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (Ra),
      .raddr_b (Rb),
      .waddr   (Rd),
      .wen     (RWrite),
      .wdata   (wr_data_s),
      .rdata_a (Data1),
      .rdata_b (Data2)
   );

endmodule : deco

// File: tb/tb_deco.sv
// Scoreboard bench for deco: the stimulus process drives one vector per
// cycle, predicts every output from an array-based register model and
// queues the prediction; a monitor on the falling edge pops and compares.
module tb_deco;

   logic        clk;
   logic        rst;
   logic [3:0]  Ra, Rb, Rd;
   logic        Branch, DataInputON, RWrite;
   logic [18:0] Imm;
   logic [31:0] DataInput;
   logic        PCSelect;
   logic [31:0] BranchDir, ImmExtend, Data1, Data2;
   logic [3:0]  RD;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [31:0] bdir;
      logic        pcs;
      logic [3:0]  rd;
      bit          chk1;
      bit          chk2;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_regs [16];
   bit          model_known [16];
   int          n_vec  = 0;
   int          n_miss = 0;
   bit          stim_done = 0;

   deco dut (
      .clk         (clk),
      .rst         (rst),
      .Ra          (Ra),
      .Rb          (Rb),
      .Rd          (Rd),
      .Branch      (Branch),
      .DataInputON (DataInputON),
      .RWrite      (RWrite),
      .Imm         (Imm),
      .DataInput   (DataInput),
      .PCSelect    (PCSelect),
      .BranchDir   (BranchDir),
      .ImmExtend   (ImmExtend),
      .Data1       (Data1),
      .Data2       (Data2),
      .RD          (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate value interpreted as a signed 19-bit number, widened to 32 bits.
   function automatic logic [31:0] ext_model(input logic [18:0] imm);
      int v;
      v = int'(imm);
      if (v >= 262144) v = v - 524288;
      return 32'(v);
   endfunction

   // Drive one vector, queue its predicted outputs, advance the model
   // by the coming clock edge, then move just past that edge.
   task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic br, input logic dion,
                        input logic rw, input logic [18:0] im, input logic [31:0] din);
      exp_t e;
      rst = r; Ra = a; Rb = b; Rd = d; Branch = br;
      DataInputON = dion; RWrite = rw; Imm = im; DataInput = din;
      e.d1   = model_regs[a];
      e.d2   = model_regs[b];
      e.chk1 = model_known[a];
      e.chk2 = model_known[b];
      e.imm  = ext_model(im);
      e.bdir = ext_model(im);
      e.pcs  = br;
      e.rd   = d;
      sb_q.push_back(e);
      if (r) begin
         for (int i = 0; i < 16; i++) begin
            model_regs[i]  = 32'd0;
            model_known[i] = 1'b1;
         end
      end else if (rw) begin
         model_regs[d]  = dion ? din : ext_model(im);
         model_known[d] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the queued prediction against the DUT mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_vec++;
         if (e.chk1 && Data1 !== e.d1) begin
            n_miss++;
            $display("FAIL data1 vec %0d: got %h want %h (Ra=%0d)", n_vec, Data1, e.d1, Ra);
         end
         if (e.chk2 && Data2 !== e.d2) begin
            n_miss++;
            $display("FAIL data2 vec %0d: got %h want %h (Rb=%0d)", n_vec, Data2, e.d2, Rb);
         end
         if (ImmExtend !== e.imm) begin
            n_miss++;
            $display("FAIL immext vec %0d: got %h want %h", n_vec, ImmExtend, e.imm);
         end
         if (BranchDir !== e.bdir) begin
            n_miss++;
            $display("FAIL branchdir vec %0d: got %h want %h", n_vec, BranchDir, e.bdir);
         end
         if (PCSelect !== e.pcs) begin
            n_miss++;
            $display("FAIL pcselect vec %0d: got %b want %b", n_vec, PCSelect, e.pcs);
         end
         if (RD !== e.rd) begin
            n_miss++;
            $display("FAIL rd vec %0d: got %0d want %0d", n_vec, RD, e.rd);
         end
      end
   end

   // Stimulus: directed scenarios first, then randomized traffic.
   initial begin
      int wait_cycles;
      for (int i = 0; i < 16; i++) begin
         model_regs[i]  = 32'd0;
         model_known[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      //      rst   Ra     Rb     Rd     Br    DIon  RW    Imm           DataInput
      apply(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 19'd0,        32'd0);
      apply(1'b0, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 19'd0,        32'd0);
      apply(1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 19'd8,        32'd10);
      apply(1'b0, 4'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 19'd8,        32'd10);
      apply(1'b0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 19'd0,        32'd11);
      apply(1'b0, 4'd4, 4'd2, 4'd4, 1'b0, 1'b1, 1'b0, 19'd0,        32'd11);
      apply(1'b0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 19'h40000,    32'd0);
      apply(1'b0, 4'd0, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 19'h40000,    32'd0);
      apply(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 19'd100,      32'd0);
      apply(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 19'd100,      32'd0);
      apply(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 19'd0,        32'hDEADBEEF);
      apply(1'b1, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 19'd0,        32'd5);
      apply(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 1'b0, 19'd0,        32'd5);
      apply(1'b0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b1, 1'b1, 19'h3FFFF,  32'hFFFFFFFF);
      apply(1'b0, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 19'h7FFFF,   32'd0);
      apply(1'b0, 4'd0, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0, 19'h3FFFF,   32'd0);

      for (int n = 0; n < 2000; n++) begin
         apply(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
               4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               19'($urandom), $urandom);
      end
      stim_done = 1'b1;

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb_q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: %0d predictions left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_deco
